// File: rtl/pcie_link_status_led_pkg.sv
// Shared LTSSM decode constants and link-state encoding for the PCIe status/LED logic.
package pcie_status_pkg;

  localparam logic [4:0] LTSSM_L0         = 5'h0F;
  localparam logic [4:0] LTSSM_POLL_COMPL = 5'h03;
  localparam logic [4:0] LTSSM_RECOV_LO   = 5'h0C;
  localparam logic [4:0] LTSSM_RECOV_HI   = 5'h0E;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    QUAL  = 2'd1,
    UP    = 2'd2,
    RECOV = 2'd3
  } link_state_e;

  function automatic logic is_recov_code(input logic [4:0] code);
    return (code >= LTSSM_RECOV_LO) && (code <= LTSSM_RECOV_HI);
  endfunction

endpackage

// File: rtl/pcie_link_status_led_rst_sync.sv
// Async-assert / sync-deassert reset synchronizer of parametrised depth (2..4 flops).
module rst_sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic sync_n
);

  logic [STAGES-1:0] sync_r;

  // Shift ones in after release; any low on arst_n clears the chain at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], 1'b1};
    end
  end

  assign sync_n = sync_r[STAGES-1];

endmodule

// File: rtl/pcie_link_status_led.sv
// Link-status and LED controller: L0 qualification, recovery blink, saturating
// link-drop counter and selectable LED polarity, driven by the ICM test bus.
module pcie_link_status_led
  import pcie_status_pkg::*;
#(
  parameter int LANE_CODE_W    = 4,
  parameter int ALIVE_W        = 26,
  parameter int SYNC_STAGES    = 2,
  parameter int L0_STABLE      = 1024,
  parameter int DROP_CNT_W     = 8,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                   pld_clk,
  input  logic                   any_rstn,
  input  logic [4:0]             ltssm,
  input  logic [LANE_CODE_W-1:0] lane_code,
  input  logic                   drop_clr,
  output logic                   link_up,
  output logic                   retrain_pulse,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
  output logic                   alive_led,
  output logic                   comp_led,
  output logic                   L0_led,
  output logic [LANE_CODE_W-1:0] lane_active_led
);

  localparam int                STAB_W    = $clog2(L0_STABLE + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(L0_STABLE - 1);
  localparam logic              LED_INV   = (LED_ACTIVE_LOW != 0);

  logic                   rst_sync_s;
  logic [ALIVE_W-1:0]     alive_cnt_r;
  logic [ALIVE_W-1:0]     alive_inc_s;
  logic [STAB_W-1:0]      stab_cnt_r;
  logic [DROP_CNT_W-1:0]  drop_cnt_r;
  link_state_e            state_r;
  logic                   link_up_r;
  logic                   retrain_r;
  logic                   l0_lit_r;
  logic                   comp_lit_r;
  logic [LANE_CODE_W-1:0] lane_lit_r;
  logic                   is_l0_s;
  logic                   is_recov_s;
  logic                   drop_evt_s;

  rst_sync_n #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk    (pld_clk),
    .arst_n (any_rstn),
    .sync_n (rst_sync_s)
  );

  assign alive_inc_s = alive_cnt_r + ALIVE_W'(1);
  assign is_l0_s     = (ltssm == LTSSM_L0);
  assign is_recov_s  = is_recov_code(ltssm);
  // A drop is leaving an established link for anything other than L0 or recovery.
  assign drop_evt_s  = ((state_r == UP) || (state_r == RECOV)) && !is_l0_s && !is_recov_s;

  // Heartbeat counter and one-cycle-delayed compliance/lane indications.
  always_ff @(posedge pld_clk or negedge rst_sync_s) begin
    if (!rst_sync_s) begin
      alive_cnt_r <= '0;
      comp_lit_r  <= 1'b0;
      lane_lit_r  <= '0;
    end else begin
      alive_cnt_r <= alive_inc_s;
      comp_lit_r  <= (ltssm == LTSSM_POLL_COMPL);
      lane_lit_r  <= lane_code;
    end
  end

  // Link FSM; link_up and the link LED are registered alongside the next state,
  // so the blink bit comes from the incremented heartbeat value.
  always_ff @(posedge pld_clk or negedge rst_sync_s) begin
    if (!rst_sync_s) begin
      state_r    <= DOWN;
      stab_cnt_r <= '0;
      link_up_r  <= 1'b0;
      retrain_r  <= 1'b0;
      l0_lit_r   <= 1'b0;
    end else begin
      retrain_r <= 1'b0;
      case (state_r)
        DOWN: begin
          if (is_l0_s) begin
            state_r    <= QUAL;
            stab_cnt_r <= STAB_W'(1);
          end
        end
        QUAL: begin
          if (!is_l0_s) begin
            state_r <= DOWN;
          end else if (stab_cnt_r >= STAB_LAST) begin
            state_r   <= UP;
            link_up_r <= 1'b1;
            l0_lit_r  <= 1'b1;
          end else begin
            stab_cnt_r <= stab_cnt_r + STAB_W'(1);
          end
        end
        UP: begin
          if (is_recov_s) begin
            state_r   <= RECOV;
            retrain_r <= 1'b1;
            l0_lit_r  <= alive_inc_s[ALIVE_W-3];
          end else if (!is_l0_s) begin
            state_r   <= DOWN;
            link_up_r <= 1'b0;
            l0_lit_r  <= 1'b0;
          end
        end
        RECOV: begin
          if (is_l0_s) begin
            state_r  <= UP;
            l0_lit_r <= 1'b1;
          end else if (is_recov_s) begin
            l0_lit_r <= alive_inc_s[ALIVE_W-3];
          end else begin
            state_r   <= DOWN;
            link_up_r <= 1'b0;
            l0_lit_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= DOWN;
          link_up_r <= 1'b0;
          l0_lit_r  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating drop counter; clear wins over a simultaneous drop.
  always_ff @(posedge pld_clk or negedge rst_sync_s) begin
    if (!rst_sync_s) begin
      drop_cnt_r <= '0;
    end else if (drop_clr) begin
      drop_cnt_r <= '0;
    end else if (drop_evt_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
    end
  end

  assign link_up         = link_up_r;
  assign retrain_pulse   = retrain_r;
  assign drop_cnt        = drop_cnt_r;
  assign alive_led       = alive_cnt_r[ALIVE_W-1] ^ LED_INV;
  assign comp_led        = comp_lit_r ^ LED_INV;
  assign L0_led          = l0_lit_r ^ LED_INV;
  assign lane_active_led = lane_lit_r ^ {LANE_CODE_W{LED_INV}};

endmodule

// File: tb/tb_pcie_link_status_led.sv
// Scoreboard bench: a spec-level model pushes expected outputs per driven cycle,
// a monitor pops and compares them after each rising edge (both LED polarities).
module tb_pcie_link_status_led;

  localparam int LANE_W  = 4;
  localparam int ALIVE_W = 6;
  localparam int SYNC    = 2;
  localparam int STABLE  = 16;
  localparam int DROP_W  = 2;

  typedef struct {
    int link;
    int ret;
    int drop;
    int alive;
    int comp;
    int l0;
    int lane;
  } exp_t;

  logic              clk;
  logic              any_rstn;
  logic [4:0]        ltssm;
  logic [LANE_W-1:0] lane_code;
  logic              drop_clr;

  logic              link_up_a, retrain_a, alive_a, comp_a, l0_a;
  logic [DROP_W-1:0] drop_a;
  logic [LANE_W-1:0] lane_a;
  logic              link_up_b, retrain_b, alive_b, comp_b, l0_b;
  logic [DROP_W-1:0] drop_b;
  logic [LANE_W-1:0] lane_b;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // model state
  int m_state, m_stab, m_drop, m_alive, m_rel;
  int m_comp, m_lane, m_ret;

  pcie_link_status_led #(
    .LANE_CODE_W(LANE_W), .ALIVE_W(ALIVE_W), .SYNC_STAGES(SYNC),
    .L0_STABLE(STABLE), .DROP_CNT_W(DROP_W), .LED_ACTIVE_LOW(1)
  ) dut_lo (
    .pld_clk(clk), .any_rstn(any_rstn), .ltssm(ltssm), .lane_code(lane_code),
    .drop_clr(drop_clr), .link_up(link_up_a), .retrain_pulse(retrain_a),
    .drop_cnt(drop_a), .alive_led(alive_a), .comp_led(comp_a), .L0_led(l0_a),
    .lane_active_led(lane_a)
  );

  pcie_link_status_led #(
    .LANE_CODE_W(LANE_W), .ALIVE_W(ALIVE_W), .SYNC_STAGES(SYNC),
    .L0_STABLE(STABLE), .DROP_CNT_W(DROP_W), .LED_ACTIVE_LOW(0)
  ) dut_hi (
    .pld_clk(clk), .any_rstn(any_rstn), .ltssm(ltssm), .lane_code(lane_code),
    .drop_clr(drop_clr), .link_up(link_up_b), .retrain_pulse(retrain_b),
    .drop_cnt(drop_b), .alive_led(alive_b), .comp_led(comp_b), .L0_led(l0_b),
    .lane_active_led(lane_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic reset_model();
    m_state = 0; m_stab = 0; m_drop = 0; m_alive = 0; m_rel = 0;
    m_comp = 0; m_lane = 0; m_ret = 0;
  endtask

  // Drive one cycle of inputs, advance the model for the coming edge, push expectation.
  task automatic step(input logic [4:0] lt, input logic [LANE_W-1:0] ln, input logic clr);
    exp_t e;
    int   is_l0, is_rec, drop_ev;
    ltssm = lt; lane_code = ln; drop_clr = clr;
    if (!any_rstn) begin
      reset_model();
    end else if (m_rel < SYNC) begin
      m_rel++;
    end else begin
      is_l0   = (lt == 5'h0F);
      is_rec  = (lt >= 5'h0C) && (lt <= 5'h0E);
      drop_ev = 0;
      m_ret   = 0;
      m_alive = (m_alive + 1) % (1 << ALIVE_W);
      m_comp  = (lt == 5'h03);
      m_lane  = int'(ln);
      case (m_state)
        0: if (is_l0) begin m_state = 1; m_stab = 1; end
        1: begin
          if (!is_l0) m_state = 0;
          else begin
            m_stab++;
            if (m_stab >= STABLE) m_state = 2;
          end
        end
        2: if (is_rec) begin m_state = 3; m_ret = 1; end
           else if (!is_l0) begin m_state = 0; drop_ev = 1; end
        default: if (is_l0) m_state = 2;
                 else if (!is_rec) begin m_state = 0; drop_ev = 1; end
      endcase
      if (clr) m_drop = 0;
      else if (drop_ev && m_drop < 3) m_drop++;
    end
    e.link  = (m_state >= 2);
    e.ret   = m_ret;
    e.drop  = m_drop;
    e.alive = (m_alive >> (ALIVE_W - 1)) & 1;
    e.comp  = m_comp;
    e.l0    = (m_state == 2) ? 1 : (m_state == 3) ? ((m_alive >> (ALIVE_W - 3)) & 1) : 0;
    e.lane  = m_lane;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n, input logic [4:0] lt);
    for (int i = 0; i < n; i++) step(lt, 4'h0, 1'b0);
  endtask

  // Compare both polarities against the oldest expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("link_up",   32'(link_up_a), 32'(e.link));
      check_eq("retrain",   32'(retrain_a), 32'(e.ret));
      check_eq("drop_cnt",  32'(drop_a),    32'(e.drop));
      check_eq("alive_lo",  32'(alive_a),   32'(e.alive ^ 1));
      check_eq("comp_lo",   32'(comp_a),    32'(e.comp ^ 1));
      check_eq("l0_lo",     32'(l0_a),      32'(e.l0 ^ 1));
      check_eq("lane_lo",   32'(lane_a),    32'(e.lane ^ 15));
      check_eq("alive_hi",  32'(alive_b),   32'(e.alive));
      check_eq("comp_hi",   32'(comp_b),    32'(e.comp));
      check_eq("l0_hi",     32'(l0_b),      32'(e.l0));
      check_eq("lane_hi",   32'(lane_b),    32'(e.lane));
      check_eq("link_up_hi", 32'(link_up_b), 32'(e.link));
    end
  end

  task automatic mid_reset();
    #2 any_rstn = 1'b0;
    #1;
    check_eq("arst_link",  32'(link_up_a), 32'd0);
    check_eq("arst_ret",   32'(retrain_a), 32'd0);
    check_eq("arst_drop",  32'(drop_a),    32'd0);
    check_eq("arst_alive", 32'(alive_a),   32'd1);
    check_eq("arst_comp",  32'(comp_a),    32'd1);
    check_eq("arst_l0",    32'(l0_a),      32'd1);
    check_eq("arst_lane",  32'(lane_a),    32'hF);
    check_eq("arst_l0_hi", 32'(l0_b),      32'd0);
    #1 any_rstn = 1'b1;
    reset_model();
  endtask

  initial begin
    any_rstn = 1'b0; ltssm = 5'h00; lane_code = 4'h0; drop_clr = 1'b0;
    reset_model();
    @(negedge clk);
    steps(3, 5'h00);
    any_rstn = 1'b1;
    // release plus heartbeat MSB toggle
    steps(40, 5'h00);
    // qualification aborted after 15 L0 cycles, then full qualification
    steps(15, 5'h0F);
    step(5'h02, 4'h0, 1'b0);
    steps(20, 5'h0F);
    // recovery excursion
    steps(40, 5'h0D);
    steps(3, 5'h0F);
    // five drops with saturation, then clear coinciding with a drop
    for (int i = 0; i < 5; i++) begin
      step(5'h00, 4'h0, 1'b0);
      steps(STABLE, 5'h0F);
    end
    step(5'h00, 4'h0, 1'b1);
    step(5'h00, 4'h0, 1'b1);
    step(5'h00, 4'h0, 1'b0);
    // compliance and lane mapping
    step(5'h03, 4'b1010, 1'b0);
    step(5'h03, 4'b1010, 1'b0);
    for (int i = 0; i < 6; i++) step(5'h01, LANE_W'($urandom_range(0, 15)), 1'b0);
    // build drop_cnt = 2 and sit in recovery, then reset asynchronously
    for (int i = 0; i < 2; i++) begin
      steps(STABLE, 5'h0F);
      step(5'h00, 4'h0, 1'b0);
    end
    steps(STABLE, 5'h0F);
    steps(3, 5'h0E);
    mid_reset();
    steps(6, 5'h0F);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
